// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - ALU result stage handshake/bus interface
//
// Groups the ALU-side enqueue signals, the writeback-side dequeue signals
// and the architectural flag/occupancy observation signals of
// alu_result_stage.
//   slave  : used by alu_result_stage (consumes ALU results, presents head)
//   master : used by the environment (ALU driver + writeback consumer)
//
// Signals:
//   in_valid/in_ready          ALU result handshake
//   alu_out/alu_zero/alu_pos   ALU result payload
//   in_tag                     destination register tag
//   set_flags                  result updates the flag register
//   out_valid/out_ready        writeback handshake
//   out_data/out_tag           head entry payload
//   flag_zero/flag_pos         architectural flags
//   count                      occupied entries, 0..DEPTH

interface alu_result_stage_if #(
    parameter int WIDTH    = 16,
    parameter int TAG_BITS = 4,
    parameter int DEPTH    = 2
) ();
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    alu_out;
    logic                alu_zero;
    logic                alu_pos;
    logic [TAG_BITS-1:0] in_tag;
    logic                set_flags;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [TAG_BITS-1:0] out_tag;
    logic                flag_zero;
    logic                flag_pos;
    logic [CNT_BITS-1:0] count;

    modport slave (
        input  in_valid, alu_out, alu_zero, alu_pos, in_tag, set_flags, out_ready,
        output in_ready, out_valid, out_data, out_tag, flag_zero, flag_pos, count
    );

    modport master (
        output in_valid, alu_out, alu_zero, alu_pos, in_tag, set_flags, out_ready,
        input  in_ready, out_valid, out_data, out_tag, flag_zero, flag_pos, count
    );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result FIFO and architectural flag register
//
// Buffers ALU results with their destination tag in a DEPTH-entry FIFO and
// presents the head entry to writeback over a valid/ready handshake. The
// zero/positive flag register updates at enqueue time, so flags are visible
// to branch logic even while writeback is stalled.
//
// Optional feature macro: ALU_RESULT_BYPASS_EN
//   When defined and the FIFO is empty, an incoming result is shown on the
//   output in the same cycle; if writeback takes it, it is never stored.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu_result_stage_if.slave (handshakes, payloads, flags, count)

module alu_result_stage #(
    parameter int WIDTH    = 16,
    parameter int TAG_BITS = 4,
    parameter int DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_result_stage_if.slave     bus
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    data_q [DEPTH];
    logic [TAG_BITS-1:0] tag_q  [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                flag_zero_q, flag_zero_d;
    logic                flag_pos_q, flag_pos_d;

    logic empty;
    logic full;
    logic in_ready;
    logic push;
    logic store;
    logic fifo_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    // Depends on registered occupancy only, never on out_ready.
    assign in_ready = !reset && !full;
    assign push     = bus.in_valid && in_ready;
    // The FIFO itself only pops when it holds something; a bypassed result
    // is consumed without touching the pointers.
    assign fifo_pop = !empty && bus.out_ready;

`ifdef ALU_RESULT_BYPASS_EN
    logic bypass_hit;
    logic bypass_take;

    // push already excludes reset, so nothing is shown during reset.
    assign bypass_hit  = empty && push;
    assign bypass_take = bypass_hit && bus.out_ready;
    assign store       = push && !bypass_take;

    assign bus.out_valid = !empty || bypass_hit;
    assign bus.out_data  = !empty    ? data_q[rd_ptr_q] :
                           bypass_hit ? bus.alu_out     : '0;
    assign bus.out_tag   = !empty    ? tag_q[rd_ptr_q]  :
                           bypass_hit ? bus.in_tag      : '0;
`else
    assign store = push;

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : data_q[rd_ptr_q];
    assign bus.out_tag   = empty ? '0 : tag_q[rd_ptr_q];
`endif

    assign bus.in_ready  = in_ready;
    assign bus.flag_zero = flag_zero_q;
    assign bus.flag_pos  = flag_pos_q;
    assign bus.count     = count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        flag_zero_d = flag_zero_q;
        flag_pos_d  = flag_pos_q;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end

        unique case ({store, fifo_pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        // Flags track every accepted result, bypassed or stored.
        if (push && bus.set_flags) begin
            flag_zero_d = bus.alu_zero;
            flag_pos_d  = bus.alu_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flag_zero_q <= 1'b0;
            flag_pos_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flag_zero_q <= flag_zero_d;
            flag_pos_q  <= flag_pos_d;
        end
    end

    // Storage needs no reset: outputs are gated by count, and store is
    // low during reset because in_ready is.
    always_ff @(posedge clk) begin
        if (store) begin
            data_q[wr_ptr_q] <= bus.alu_out;
            tag_q[wr_ptr_q]  <= bus.in_tag;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage

module tb_alu_result_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_result_stage_if #(.WIDTH(16), .TAG_BITS(4), .DEPTH(2)) bus ();

    alu_result_stage #(.WIDTH(16), .TAG_BITS(4), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] t,
                         input logic sf, input logic z, input logic p);
        bus.in_valid  = v;
        bus.alu_out   = d;
        bus.in_tag    = t;
        bus.set_flags = sf;
        bus.alu_zero  = z;
        bus.alu_pos   = p;
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset with a stale entry (flags set before reset)
        drive(1'b1, 16'h0002, 4'd3, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check_eq("stale_count", 32'(bus.count), 32'd1);
        check_eq("stale_flag_zero", 32'(bus.flag_zero), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("in_reset_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check_eq("rst2_count", 32'(bus.count), 32'd0);
        check_eq("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst2_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst2_out_tag", 32'(bus.out_tag), 32'd0);
        check_eq("rst2_flag_zero", 32'(bus.flag_zero), 32'd0);
        check_eq("rst2_flag_pos", 32'(bus.flag_pos), 32'd0);
        reset = 1'b0;
        step();
        check_eq("rst2_after_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst2_after_count", 32'(bus.count), 32'd0);

        // Single transfer
        drive(1'b1, 16'h0002, 4'd5, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check_eq("single_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("single_out_data", 32'(bus.out_data), 32'h2);
        check_eq("single_out_tag", 32'(bus.out_tag), 32'd5);
        check_eq("single_flag_pos", 32'(bus.flag_pos), 32'd1);
        check_eq("single_flag_zero", 32'(bus.flag_zero), 32'd0);
        bus.out_ready = 1'b1;
        step();
        check_eq("single_pop_count", 32'(bus.count), 32'd0);
        check_eq("single_pop_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("single_pop_out_data", 32'(bus.out_data), 32'd0);
        // Pop while empty is ignored
        step();
        check_eq("empty_pop_count", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b0;

        // Fill and stall
        drive(1'b1, 16'h0002, 4'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0000, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("full_count", 32'(bus.count), 32'd2);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 16'h0BAD, 4'd9, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check_eq("full_ignored_count", 32'(bus.count), 32'd2);
        check_eq("full_ignored_flag_zero", 32'(bus.flag_zero), 32'd0);
        check_eq("full_head_data", 32'(bus.out_data), 32'h2);
        check_eq("full_head_tag", 32'(bus.out_tag), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check_eq("full_popping_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check_eq("drain1_count", 32'(bus.count), 32'd1);
        check_eq("drain1_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("drain1_data", 32'(bus.out_data), 32'h0);
        check_eq("drain1_tag", 32'(bus.out_tag), 32'd2);
        check_eq("drain1_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        check_eq("drain2_count", 32'(bus.count), 32'd0);
        bus.out_ready = 1'b0;

        // Simultaneous push/pop at count=1, across pointer wrap
        drive(1'b1, 16'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 2; i <= 6; i++) begin
            drive(1'b1, 16'(i), 4'(i), 1'b0, 1'b0, 1'b0);
            bus.out_ready = 1'b1;
            #1;
            check_eq($sformatf("stream_head_%0d", i - 1), 32'(bus.out_data), 32'(i - 1));
            step();
            check_eq($sformatf("stream_count_%0d", i), 32'(bus.count), 32'd1);
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("stream_head_6", 32'(bus.out_data), 32'd6);
        check_eq("stream_tag_6", 32'(bus.out_tag), 32'd6);
        step();
        check_eq("stream_end_count", 32'(bus.count), 32'd0);

        // Flag hold (writeback draining throughout)
        drive(1'b1, 16'h0000, 4'd4, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0007, 4'd4, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check_eq("hold_flag_zero", 32'(bus.flag_zero), 32'd1);
        check_eq("hold_flag_pos", 32'(bus.flag_pos), 32'd0);
        step();
        step();
        check_eq("hold_drained_count", 32'(bus.count), 32'd0);

        // Empty, out_ready=1, push 0x0010: bypass vs one-cycle latency
        drive(1'b1, 16'h0010, 4'd7, 1'b1, 1'b0, 1'b1);
        #1;
`ifdef ALU_RESULT_BYPASS_EN
        check_eq("byp_same_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("byp_same_out_data", 32'(bus.out_data), 32'h10);
        check_eq("byp_same_out_tag", 32'(bus.out_tag), 32'd7);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("byp_count", 32'(bus.count), 32'd0);
        check_eq("byp_next_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("byp_flag_pos", 32'(bus.flag_pos), 32'd1);
`else
        check_eq("nobyp_same_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("nobyp_same_out_data", 32'(bus.out_data), 32'd0);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("nobyp_next_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("nobyp_next_out_data", 32'(bus.out_data), 32'h10);
        check_eq("nobyp_next_out_tag", 32'(bus.out_tag), 32'd7);
        check_eq("nobyp_count", 32'(bus.count), 32'd1);
        check_eq("nobyp_flag_pos", 32'(bus.flag_pos), 32'd1);
        step();
        check_eq("nobyp_drain_count", 32'(bus.count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
